note_recorder: RTL and testbench

//   Writer side of the song note table. It quantizes the live note stream from the

---
 rtl/note_recorder.sv | 144 ++++++++++++++
 tb/tb_note_recorder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
`timescale 1ns/1ps
// note_recorder: quantizes the live note stream into fixed-length time slots and
// builds the packed song table ({valid, note} per slot) read by playback/compare.
module note_recorder #(
  parameter int SLOTS          = 160,
  parameter int NOTE_W         = 5,
  parameter int TICKS_PER_SLOT = 6_250_000
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic                          note_valid_in,
  input  logic [NOTE_W-1:0]             note_in,
  output logic [SLOTS-1:0][NOTE_W:0]    song_out,
  output logic [$clog2(SLOTS+1)-1:0]    slot_idx_out,
  output logic                          recording_out,
  output logic                          done_out,
  output logic                          full_out
);

  localparam int IDX_W  = $clog2(SLOTS + 1);
  localparam int ADDR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int TICK_W = (TICKS_PER_SLOT > 1) ? $clog2(TICKS_PER_SLOT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SLOT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SLOTS - 1);
  localparam logic [IDX_W-1:0]  IDX_END   = IDX_W'(SLOTS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [TICK_W-1:0]          tick;
  logic                       seen;
  logic [NOTE_W-1:0]          last_note;
  logic [IDX_W-1:0]           slot_idx;
  logic [SLOTS-1:0][NOTE_W:0] song_q;
  logic                       recording_q;
  logic                       done_q;
  logic                       full_q;

  logic                       clear;
  logic                       slot_end;
  logic                       commit;
  logic [NOTE_W-1:0]          note_now;
  logic [NOTE_W:0]            entry;
  logic [ADDR_W-1:0]          wr_addr;

  assign wr_addr = slot_idx[ADDR_W-1:0];

  // State register; reset drops straight back to IDLE even mid-recording.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a recording ends on the final slot boundary or on stop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_in) next_state = RECORD;
      RECORD:  if (stop_in || (slot_end && (slot_idx == IDX_LAST))) next_state = DONE;
      DONE:    if (start_in) next_state = RECORD;
      default: next_state = IDLE;
    endcase
  end

  // Control decode: the current cycle's sample already counts toward the slot
  // being closed, so a valid note now overrides the latched one in the entry.
  always_comb begin
    clear    = 1'b0;
    slot_end = 1'b0;
    commit   = 1'b0;
    note_now = last_note;
    entry    = '0;
    if (note_valid_in) note_now = note_in;
    if (state == RECORD) begin
      slot_end = (tick == TICK_LAST);
      commit   = slot_end || (stop_in && (seen || note_valid_in));
    end else begin
      clear = start_in;
    end
    if (seen || note_valid_in) entry = {1'b1, note_now};
  end

  // Slot timing, note capture and table writes; an empty stop commits nothing.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      tick      <= '0;
      seen      <= 1'b0;
      last_note <= '0;
      slot_idx  <= '0;
      song_q    <= '0;
      full_q    <= 1'b0;
    end else if (clear) begin
      tick     <= '0;
      seen     <= 1'b0;
      slot_idx <= '0;
      song_q   <= '0;
      full_q   <= 1'b0;
    end else if (state == RECORD) begin
      if (slot_end) begin
        tick <= '0;
        seen <= 1'b0;
      end else begin
        tick <= tick + TICK_W'(1);
        if (note_valid_in) seen <= 1'b1;
      end
      if (note_valid_in) last_note <= note_in;
      if (commit && (slot_idx < IDX_END)) begin
        song_q[wr_addr] <= entry;
        slot_idx        <= slot_idx + IDX_W'(1);
        if (slot_idx == IDX_LAST) full_q <= 1'b1;
      end
    end
  end

  // Registered status flags; done fires only on the RECORD-to-DONE transition.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      recording_q <= (next_state == RECORD);
      done_q      <= (state == RECORD) && (next_state == DONE);
    end
  end

  assign song_out      = song_q;
  assign slot_idx_out  = slot_idx;
  assign recording_out = recording_q;
  assign done_out      = done_q;
  assign full_out      = full_q;

endmodule

// File: tb/tb_note_recorder.sv
`timescale 1ns/1ps
// tb_note_recorder: directed checks of the note recorder with a small table
// (8 slots of 4 ticks) and hand-computed expected entries.
module tb_note_recorder;

  localparam int SLOTS  = 8;
  localparam int NOTE_W = 5;
  localparam int TPS    = 4;

  logic                       clk_in = 1'b0;
  logic                       rst_in_n = 1'b0;
  logic                       start_in = 1'b0;
  logic                       stop_in = 1'b0;
  logic                       note_valid_in = 1'b0;
  logic [NOTE_W-1:0]          note_in = '0;
  logic [SLOTS-1:0][NOTE_W:0] song_out;
  logic [3:0]                 slot_idx_out;
  logic                       recording_out;
  logic                       done_out;
  logic                       full_out;

  int checks = 0;
  int errors = 0;
  int doneCount;
  logic [SLOTS*(NOTE_W+1)-1:0] allThirteen;

  note_recorder #(
    .SLOTS(SLOTS),
    .NOTE_W(NOTE_W),
    .TICKS_PER_SLOT(TPS)
  ) dut (
    .clk_in(clk_in),
    .rst_in_n(rst_in_n),
    .start_in(start_in),
    .stop_in(stop_in),
    .note_valid_in(note_valid_in),
    .note_in(note_in),
    .song_out(song_out),
    .slot_idx_out(slot_idx_out),
    .recording_out(recording_out),
    .done_out(done_out),
    .full_out(full_out)
  );

  // 100 MHz clock
  always #5 clk_in = ~clk_in;

  // Compare one observed value against its expected value and tally it
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive inputs for one clock cycle; returns 1 ns after the edge
  task automatic applyStimulus(input logic start, input logic stop,
                               input logic valid, input logic [NOTE_W-1:0] note);
    start_in      = start;
    stop_in       = stop;
    note_valid_in = valid;
    note_in       = note;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkEntry(input int idx, input logic [NOTE_W:0] expected);
    checkOutput($sformatf("entry%0d", idx), 64'(song_out[idx]), 64'(expected));
  endtask

  // Safety net so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < SLOTS; i++) allThirteen[i*6 +: 6] = 6'h2D;

    // power-on reset
    #12;
    checkOutput("por_song", 64'(song_out), 64'd0);
    checkOutput("por_slot", 64'(slot_idx_out), 64'd0);
    checkOutput("por_rec", 64'(recording_out), 64'd0);
    checkOutput("por_done", 64'(done_out), 64'd0);
    checkOutput("por_full", 64'(full_out), 64'd0);
    rst_in_n = 1'b1;
    @(posedge clk_in);
    #1;

    // held note 13 for 12 cycles fills three slots
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput("t2_rec", 64'(recording_out), 64'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    for (int i = 0; i < 3; i++) checkEntry(i, 6'h2D);
    for (int i = 3; i < SLOTS; i++) checkEntry(i, 6'h00);
    checkOutput("t2_slot", 64'(slot_idx_out), 64'd3);
    checkOutput("t2_full", 64'(full_out), 64'd0);

    // asynchronous reset mid-recording, checked before any clock edge
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    rst_in_n = 1'b0;
    #2;
    checkOutput("t1_song", 64'(song_out), 64'd0);
    checkOutput("t1_slot", 64'(slot_idx_out), 64'd0);
    checkOutput("t1_rec", 64'(recording_out), 64'd0);
    checkOutput("t1_done", 64'(done_out), 64'd0);
    checkOutput("t1_full", 64'(full_out), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    rst_in_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("t1_idle_rec", 64'(recording_out), 64'd0);

    // empty slot, then last-valid-wins slot, then empty stop writes nothing
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd8);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd15);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkEntry(0, 6'h00);
    checkEntry(1, 6'h2F);
    checkOutput("t3_slot", 64'(slot_idx_out), 64'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkOutput("t3_done", 64'(done_out), 64'd1);
    checkOutput("t3_rec", 64'(recording_out), 64'd0);
    checkOutput("t3_full", 64'(full_out), 64'd0);
    checkOutput("t3_stop_slot", 64'(slot_idx_out), 64'd2);
    checkEntry(2, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("t3_done_pulse", 64'(done_out), 64'd0);

    // restart from DONE clears the table, then fill all slots
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    checkOutput("t4_clear_song", 64'(song_out), 64'd0);
    checkOutput("t4_clear_slot", 64'(slot_idx_out), 64'd0);
    checkOutput("t4_rec_on", 64'(recording_out), 64'd1);
    doneCount = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
      if (done_out) doneCount++;
    end
    checkOutput("t4_song", 64'(song_out), 64'(allThirteen));
    checkOutput("t4_full", 64'(full_out), 64'd1);
    checkOutput("t4_rec_off", 64'(recording_out), 64'd0);
    checkOutput("t4_slot", 64'(slot_idx_out), 64'd8);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, (i < 2), 1'b1, 5'd3);
      if (done_out) doneCount++;
    end
    checkOutput("t4_hold_song", 64'(song_out), 64'(allThirteen));
    checkOutput("t4_done_count", 64'(doneCount), 64'd1);

    // start during RECORD is ignored; stop commits a partial slot
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd13);
    checkOutput("t6_slot_mid", 64'(slot_idx_out), 64'd0);
    checkOutput("t6_rec_mid", 64'(recording_out), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    checkOutput("t6_slot_end", 64'(slot_idx_out), 64'd1);
    checkEntry(0, 6'h2D);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkEntry(1, 6'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd17);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkEntry(2, 6'h31);
    checkEntry(3, 6'h00);
    checkOutput("t5_slot", 64'(slot_idx_out), 64'd3);
    checkOutput("t5_done", 64'(done_out), 64'd1);
    checkOutput("t5_full", 64'(full_out), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("t5_done_pulse", 64'(done_out), 64'd0);

    // stop coinciding with a slot end writes exactly once
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd17);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd2);
    checkEntry(0, 6'h22);
    checkEntry(1, 6'h00);
    checkOutput("t5b_slot", 64'(slot_idx_out), 64'd1);
    checkOutput("t5b_done", 64'(done_out), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);

    // stop coinciding with the last slot end
    applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b0, 1'b1, 5'd13);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd1);
    checkEntry(6, 6'h2D);
    checkEntry(7, 6'h21);
    checkOutput("last_slot", 64'(slot_idx_out), 64'd8);
    checkOutput("last_full", 64'(full_out), 64'd1);
    checkOutput("last_done", 64'(done_out), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkOutput("last_done_pulse", 64'(done_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
